r5p_ins_encoder: RTL and testbench

Pipelined RISC-V RV32 instruction encoder: the inverse of the R5P partial instruction decoder. It accepts an instruction format selector plus fields (opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) over a valid/ready stream. It emits the packed 32-bit instruction word on an output valid/ready stream through a 2-entry skid buffer. It sits between test/boot-ROM generators (or a debug-module instruction injector) and the core's fetch path.

---
 rtl/riscv_isa_pkg.sv | 176 +++++++++++++++++
 rtl/r5p_skid_buf.sv | 56 +++++
 rtl/r5p_ins_encoder.sv | 58 +++++
 tb/tb_r5p_ins_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_isa_pkg.sv
// RV32 ISA definitions shared by the R5P decoder, the instruction encoder and
// benches: format selector, base opcodes, the op32_t instruction-word union and
// pure encode / immediate-range helpers.
package riscv_isa_pkg;

    // Instruction format selector; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    // Base opcodes (bits [6:0])
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } op32_r_t;

    typedef struct packed {
        logic [11:0] imm_11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } op32_i_t;

    typedef struct packed {
        logic [6:0] imm_11_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_4_0;
        logic [6:0] opcode;
    } op32_s_t;

    typedef struct packed {
        logic       imm_12;
        logic [5:0] imm_10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm_4_1;
        logic       imm_11;
        logic [6:0] opcode;
    } op32_b_t;

    typedef struct packed {
        logic [19:0] imm_31_12;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } op32_u_t;

    typedef struct packed {
        logic       imm_20;
        logic [9:0] imm_10_1;
        logic       imm_11;
        logic [7:0] imm_19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } op32_j_t;

    // One 32-bit word, viewed through each base format
    typedef union packed {
        op32_r_t r;
        op32_i_t i;
        op32_s_t s;
        op32_b_t b;
        op32_u_t u;
        op32_j_t j;
    } op32_t;

    // Raw fields supplied to the encoder
    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ins_fields_t;

    // Pack the fields into an instruction word; illegal formats give all zeros.
    // Out-of-range immediates are simply truncated to the bits the format holds.
    function automatic op32_t ins_encode(input logic [2:0] fmt, input ins_fields_t f);
        op32_t op;
        op = '0;
        case (fmt)
            FMT_R: begin
                op.r.funct7 = f.f7;
                op.r.rs2    = f.rs2;
                op.r.rs1    = f.rs1;
                op.r.funct3 = f.f3;
                op.r.rd     = f.rd;
                op.r.opcode = f.opc;
            end
            FMT_I: begin
                op.i.imm_11_0 = f.imm[11:0];
                op.i.rs1      = f.rs1;
                op.i.funct3   = f.f3;
                op.i.rd       = f.rd;
                op.i.opcode   = f.opc;
            end
            FMT_S: begin
                op.s.imm_11_5 = f.imm[11:5];
                op.s.rs2      = f.rs2;
                op.s.rs1      = f.rs1;
                op.s.funct3   = f.f3;
                op.s.imm_4_0  = f.imm[4:0];
                op.s.opcode   = f.opc;
            end
            FMT_B: begin
                op.b.imm_12   = f.imm[12];
                op.b.imm_10_5 = f.imm[10:5];
                op.b.rs2      = f.rs2;
                op.b.rs1      = f.rs1;
                op.b.funct3   = f.f3;
                op.b.imm_4_1  = f.imm[4:1];
                op.b.imm_11   = f.imm[11];
                op.b.opcode   = f.opc;
            end
            FMT_U: begin
                op.u.imm_31_12 = f.imm[31:12];
                op.u.rd        = f.rd;
                op.u.opcode    = f.opc;
            end
            FMT_J: begin
                op.j.imm_20    = f.imm[20];
                op.j.imm_10_1  = f.imm[10:1];
                op.j.imm_11    = f.imm[11];
                op.j.imm_19_12 = f.imm[19:12];
                op.j.rd        = f.rd;
                op.j.opcode    = f.opc;
            end
            default: op = '0;
        endcase
        return op;
    endfunction

    // Returns 1 when the immediate cannot be represented in the format,
    // or when the format code itself is illegal.
    function automatic logic imm_check(input logic [2:0] fmt, input logic [31:0] imm);
        logic signed [31:0] simm;
        logic               err;
        simm = imm;
        err  = 1'b0;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        err = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            FMT_U:        err = |imm[11:0];
            FMT_J:        err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/r5p_skid_buf.sv
// Two-entry FIFO skid buffer carrying {err, ins}. Ready and valid are both
// derived from the registered occupancy only, so there is no combinational
// path between the two handshakes and no empty-buffer bypass.
module r5p_skid_buf
    import riscv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [32:0] in_dat,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [32:0] out_dat
);

    logic [1:0]  cnt_reg;
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [32:0] mem_reg [2];
    logic        push;
    logic        pop;

    assign in_rdy  = (cnt_reg != 2'd2);
    assign out_vld = (cnt_reg != 2'd0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    // The head entry is never overwritten while occupied, so this stays stable under stall
    assign out_dat = mem_reg[rd_ptr_reg];

    // Entry storage, pointers and occupancy; reset drops and clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                mem_reg[k] <= '0;
            end
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= in_dat;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 2'd1;
                2'b01:   cnt_reg <= cnt_reg - 2'd1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: rtl/r5p_ins_encoder.sv
// RV32 instruction encoder: combinationally packs format + fields into an
// instruction word with a representability flag, then queues the result in a
// 2-entry skid buffer towards the fetch path.
module r5p_ins_encoder
    import riscv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opc,
    input  logic [2:0]  in_f3,
    input  logic [6:0]  in_f7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_ins,
    output logic        out_err
);

    ins_fields_t fields;
    op32_t       enc_ins;
    logic        enc_err;
    logic [32:0] out_dat;

    // Encode the presented fields; the buffer captures the result on transfer
    always_comb begin
        fields     = '0;
        fields.opc = in_opc;
        fields.f3  = in_f3;
        fields.f7  = in_f7;
        fields.rd  = in_rd;
        fields.rs1 = in_rs1;
        fields.rs2 = in_rs2;
        fields.imm = in_imm;
        enc_ins    = ins_encode(in_fmt, fields);
        enc_err    = imm_check(in_fmt, in_imm);
    end

    r5p_skid_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_dat  ({enc_err, enc_ins}),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat)
    );

    assign out_err = out_dat[32];
    assign out_ins = out_dat[31:0];

endmodule

// File: tb/tb_r5p_ins_encoder.sv
// Bench for r5p_ins_encoder: hand-computed vector table, backpressure and
// mid-stream reset sequences, then a random vld/rdy scoreboard run.
module tb_r5p_ins_encoder;
    import riscv_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opc;
    logic [2:0]  in_f3;
    logic [6:0]  in_f7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_ins;
    logic        out_err;

    always #5 clk = ~clk;

    r5p_ins_encoder u_dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_fmt  (in_fmt),
        .in_opc  (in_opc),
        .in_f3   (in_f3),
        .in_f7   (in_f7),
        .in_rd   (in_rd),
        .in_rs1  (in_rs1),
        .in_rs2  (in_rs2),
        .in_imm  (in_imm),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_ins (out_ins),
        .out_err (out_err)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] ins;
        logic        err;
    } vec_t;

    localparam int NVEC = 20;
    vec_t        vt [NVEC];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [32:0] q [$];

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] ins, input logic err);
        vec_t v;
        v.fmt = fmt; v.opc = opc; v.f3 = f3; v.f7 = f7;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.ins = ins; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check handshake state against the model
    // queue, score a pop, record a push; values hold through the next posedge.
    task automatic step(input logic v, input vec_t x, input logic [32:0] e,
                        input logic r, output logic acc);
        logic [32:0] exp;
        @(negedge clk);
        in_vld = v;
        in_fmt = x.fmt; in_opc = x.opc; in_f3 = x.f3; in_f7 = x.f7;
        in_rd = x.rd; in_rs1 = x.rs1; in_rs2 = x.rs2; in_imm = x.imm;
        out_rdy = r;
        chk("in_rdy", 33'(in_rdy), 33'(q.size() < 2));
        chk("out_vld", 33'(out_vld), 33'(q.size() > 0));
        if (out_vld && r && q.size() > 0) begin
            exp = q.pop_front();
            chk("out_data", {out_err, out_ins}, exp);
            $display("xfer out: ins=%h err=%b", out_ins, out_err);
        end
        acc = v && in_rdy;
        if (acc) q.push_back(e);
    endtask

    function automatic vec_t rnd_vec();
        vec_t        v;
        ins_fields_t f;
        v.fmt = 3'($urandom_range(0, 7));
        v.opc = 7'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        case ($urandom_range(0, 2))
            0:       v.imm = $urandom;
            1:       v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: v.imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        endcase
        f.opc = v.opc; f.f3 = v.f3; f.f7 = v.f7;
        f.rd = v.rd; f.rs1 = v.rs1; f.rs2 = v.rs2; f.imm = v.imm;
        v.ins = ins_encode(v.fmt, f);
        v.err = imm_check(v.fmt, v.imm);
        return v;
    endfunction

    initial begin
        logic        acc;
        logic [31:0] hold;
        int          k;
        int          cyc;
        int          pushes;
        vec_t        z;
        vec_t        rv;

        //            fmt    opc     f3    f7     rd    rs1   rs2   imm           ins           err
        vt[0]  = mk(FMT_I, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd5,        32'h00510093, 1'b0);
        vt[1]  = mk(FMT_R, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0);
        vt[2]  = mk(FMT_S, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'd8,        32'h00512423, 1'b0);
        vt[3]  = mk(FMT_U, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0);
        vt[4]  = mk(FMT_J, 7'h6f, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0);
        vt[5]  = mk(FMT_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b1);
        vt[6]  = mk(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048,     32'h80000013, 1'b1);
        vt[7]  = mk(FMT_U, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000001, 32'h00000037, 1'b1);
        vt[8]  = mk(3'd7,  7'h13, 3'd1, 7'h7f, 5'd9, 5'd9, 5'd9, 32'd4,        32'h00000000, 1'b1);
        vt[9]  = mk(3'd6,  7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0,        32'h00000000, 1'b1);
        vt[10] = mk(FMT_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        vt[11] = mk(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000013, 1'b0);
        vt[12] = mk(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2047,     32'h7FF00013, 1'b0);
        vt[13] = mk(FMT_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0);
        vt[14] = mk(FMT_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096,     32'h80000063, 1'b1);
        vt[15] = mk(FMT_J, 7'h6f, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 32'h8000006F, 1'b0);
        vt[16] = mk(FMT_J, 7'h6f, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00100000, 32'h8000006F, 1'b1);
        vt[17] = mk(FMT_S, 7'h23, 3'd2, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFE002FA3, 1'b0);
        vt[18] = mk(FMT_J, 7'h6f, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd1,        32'h0000006F, 1'b1);
        vt[19] = mk(FMT_U, 7'h37, 3'd7, 7'h7f, 5'd5, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF2B7, 1'b0);
        z = vt[0];

        // Reset state
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        in_fmt = '0; in_opc = '0; in_f3 = '0; in_f7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", 33'(out_vld), 33'(0));
        chk("rst_in_rdy", 33'(in_rdy), 33'(1));
        chk("rst_out_ins", 33'(out_ins), 33'(0));
        chk("rst_out_err", 33'(out_err), 33'(0));
        @(negedge clk);
        rst = 1'b0;

        // Table: push into an empty buffer, then pop one cycle later
        for (int i = 0; i < NVEC; i++) begin
            step(1'b1, vt[i], {vt[i].err, vt[i].ins}, 1'b1, acc);
            chk("vec_accept", 33'(acc), 33'(1));
            step(1'b0, vt[i], 33'(0), 1'b1, acc);
            $display("vec %0d: fmt=%0d imm=%h -> ins=%h err=%b", i, vt[i].fmt, vt[i].imm,
                     vt[i].ins, vt[i].err);
        end

        // Backpressure: 5 back-to-back inputs, out_rdy low for 4 cycles
        k = 0; cyc = 0; hold = '0;
        while ((k < 5 || q.size() > 0) && cyc < 40) begin
            step(k < 5, vt[k < 5 ? k : 0], {vt[k < 5 ? k : 0].err, vt[k < 5 ? k : 0].ins},
                 cyc >= 4, acc);
            if (cyc == 2 || cyc == 3) chk("bp_in_rdy_low", 33'(in_rdy), 33'(0));
            if (cyc == 2) hold = out_ins;
            if (cyc == 3) chk("bp_stable", 33'(out_ins), 33'(hold));
            if (acc) k++;
            cyc++;
        end
        chk("bp_done", 33'(cyc < 40), 33'(1));

        // Mid-stream reset with 2 entries buffered
        step(1'b1, vt[1], {vt[1].err, vt[1].ins}, 1'b0, acc);
        step(1'b1, vt[2], {vt[2].err, vt[2].ins}, 1'b0, acc);
        step(1'b0, z, 33'(0), 1'b0, acc);
        chk("full_out_vld", 33'(out_vld), 33'(1));
        chk("full_in_rdy", 33'(in_rdy), 33'(0));
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_out_vld", 33'(out_vld), 33'(0));
        chk("mrst_in_rdy", 33'(in_rdy), 33'(1));
        chk("mrst_out_ins", 33'(out_ins), 33'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_rdy = 1'b1;
        step(1'b0, z, 33'(0), 1'b1, acc);

        // Random vld/rdy stream against the package model
        pushes = 0; cyc = 0;
        while (pushes < 10000 && cyc < 60000) begin
            rv = rnd_vec();
            step($urandom_range(0, 3) != 0, rv, {rv.err, rv.ins}, $urandom_range(0, 3) != 0, acc);
            if (acc) pushes++;
            cyc++;
        end
        while (q.size() > 0 && cyc < 60000) begin
            step(1'b0, z, 33'(0), 1'b1, acc);
            cyc++;
        end
        chk("rand_complete", 33'(cyc < 60000), 33'(1));
        step(1'b0, z, 33'(0), 1'b1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
